// File: rtl/frame_ram_arbiter.sv
// -----------------------------------------------------------------------------
// frame_ram_arbiter
//
// Shares one single-port frame RAM between two requesters:
//   - a display read controller (latency-critical), and
//   - a host writer.
// Reads win by default. A starvation counter forces one write through after
// STARVE_LIMIT consecutive read grants that a pending write had to wait behind.
//
// Ports
//   clk_in, reset_in                  rising-edge clock, sync active-high reset
//   rd_req_in / rd_addr_in            read request (held until granted)
//   rd_grant_out                      read accepted this cycle (combinational)
//   rd_valid_out / rd_data_out        read return, 2 cycles after the grant
//   wr_req_in / wr_addr_in / wr_data_in   write request (held until granted)
//   wr_grant_out                      write accepted this cycle (combinational)
//   ram_we_out / ram_addr_out / ram_wdata_out   registered RAM port
//   ram_rdata_in                      RAM read data, 1-cycle registered latency
// -----------------------------------------------------------------------------
module frame_ram_arbiter #(
    parameter int ADDR_WIDTH   = 13,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 16
) (
    input  logic                  clk_in,
    input  logic                  reset_in,
    input  logic                  rd_req_in,
    input  logic [ADDR_WIDTH-1:0] rd_addr_in,
    output logic                  rd_grant_out,
    output logic [DATA_WIDTH-1:0] rd_data_out,
    output logic                  rd_valid_out,
    input  logic                  wr_req_in,
    input  logic [ADDR_WIDTH-1:0] wr_addr_in,
    input  logic [DATA_WIDTH-1:0] wr_data_in,
    output logic                  wr_grant_out,
    output logic                  ram_we_out,
    output logic [ADDR_WIDTH-1:0] ram_addr_out,
    output logic [DATA_WIDTH-1:0] ram_wdata_out,
    input  logic [DATA_WIDTH-1:0] ram_rdata_in
);

    localparam int                CNT_W     = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(STARVE_LIMIT);
    // Grant -> RAM address register -> RAM output register.
    localparam int                RD_STAGES = 2;

    logic [CNT_W-1:0]      starve_cnt_q, starve_cnt_d;
    logic [RD_STAGES-1:0]  vld_pipe_q,   vld_pipe_d;
    logic                  ram_we_q,     ram_we_d;
    logic [ADDR_WIDTH-1:0] ram_addr_q,   ram_addr_d;
    logic [DATA_WIDTH-1:0] ram_wdata_q,  ram_wdata_d;

    logic starve_force;
    logic rd_grant;
    logic wr_grant;

    // Arbitration depends only on requests, reset and the counter; RAM read
    // data never feeds back into it.
    always_comb begin
        starve_force = rd_req_in && wr_req_in && (starve_cnt_q == CNT_MAX);
        rd_grant     = !reset_in && rd_req_in && !starve_force;
        wr_grant     = !reset_in && wr_req_in && !rd_grant;
    end

    always_comb begin
        // Counter only tracks an uninterrupted wait: a dropped write request
        // or a serviced write starts the count over.
        starve_cnt_d = starve_cnt_q;
        if (!wr_req_in || wr_grant) begin
            starve_cnt_d = '0;
        end else if (rd_grant && (starve_cnt_q != CNT_MAX)) begin
            starve_cnt_d = starve_cnt_q + CNT_W'(1);
        end

        vld_pipe_d = {vld_pipe_q[RD_STAGES-2:0], rd_grant};

        // Idle cycles leave address/data parked; only the write enable drops.
        ram_we_d    = wr_grant;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        if (wr_grant) begin
            ram_addr_d  = wr_addr_in;
            ram_wdata_d = wr_data_in;
        end else if (rd_grant) begin
            ram_addr_d  = rd_addr_in;
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            starve_cnt_q <= '0;
            vld_pipe_q   <= '0;
            ram_we_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            vld_pipe_q   <= vld_pipe_d;
            ram_we_q     <= ram_we_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
        end
    end

    // Masking with reset_in kills in-flight reads and a write that was granted
    // the cycle before reset rose, so nothing leaks out once reset is seen.
    assign rd_grant_out  = rd_grant;
    assign wr_grant_out  = wr_grant;
    assign rd_valid_out  = vld_pipe_q[RD_STAGES-1] && !reset_in;
    assign rd_data_out   = rd_valid_out ? ram_rdata_in : '0;
    assign ram_we_out    = ram_we_q && !reset_in;
    assign ram_addr_out  = ram_addr_q;
    assign ram_wdata_out = ram_wdata_q;

endmodule

// File: tb/tb_frame_ram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_frame_ram_arbiter
//
// Directed bench for frame_ram_arbiter with a behavioural single-port RAM
// (registered read, write-first). Inputs change 1 time unit after a rising
// edge; outputs are sampled 1 time unit after that.
// -----------------------------------------------------------------------------
module tb_frame_ram_arbiter;

    localparam int AW    = 13;
    localparam int DW    = 32;
    localparam int DEPTH = 1 << AW;

    logic          clk_in = 1'b0;
    logic          reset_in;
    logic          rd_req_in;
    logic [AW-1:0] rd_addr_in;
    logic          rd_grant_out;
    logic [DW-1:0] rd_data_out;
    logic          rd_valid_out;
    logic          wr_req_in;
    logic [AW-1:0] wr_addr_in;
    logic [DW-1:0] wr_data_in;
    logic          wr_grant_out;
    logic          ram_we_out;
    logic [AW-1:0] ram_addr_out;
    logic [DW-1:0] ram_wdata_out;
    logic [DW-1:0] ram_rdata_in;

    int n_tests = 0;
    int n_fail  = 0;

    frame_ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(16)) dut (
        .clk_in        (clk_in),
        .reset_in      (reset_in),
        .rd_req_in     (rd_req_in),
        .rd_addr_in    (rd_addr_in),
        .rd_grant_out  (rd_grant_out),
        .rd_data_out   (rd_data_out),
        .rd_valid_out  (rd_valid_out),
        .wr_req_in     (wr_req_in),
        .wr_addr_in    (wr_addr_in),
        .wr_data_in    (wr_data_in),
        .wr_grant_out  (wr_grant_out),
        .ram_we_out    (ram_we_out),
        .ram_addr_out  (ram_addr_out),
        .ram_wdata_out (ram_wdata_out),
        .ram_rdata_in  (ram_rdata_in)
    );

    always #5 clk_in = ~clk_in;

    // Frame RAM model: one port, registered read, write-first.
    logic [DW-1:0] mem [0:DEPTH-1];
    always @(posedge clk_in) begin
        if (ram_we_out) begin
            mem[ram_addr_out] <= ram_wdata_out;
            ram_rdata_in      <= ram_wdata_out;
        end else begin
            ram_rdata_in      <= mem[ram_addr_out];
        end
    end

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    // Streams n reads of addresses 0..n-1 and scores the return stream against
    // data == address, valid exactly in cycles 2..n+1.
    task automatic read_burst(input int n, output int nvalid, output int nbad);
        logic ev;
        nvalid = 0;
        nbad   = 0;
        for (int c = 0; c < n + 4; c++) begin
            rd_req_in  = (c < n);
            rd_addr_in = c[AW-1:0];
            #1;
            ev = (c >= 2) && (c < n + 2);
            if ((c < n) && (rd_grant_out !== 1'b1)) nbad++;
            if (rd_valid_out !== ev) nbad++;
            if (rd_valid_out === 1'b1) begin
                if (rd_data_out !== DW'(nvalid)) nbad++;
                nvalid++;
            end
            step();
        end
        rd_req_in = 1'b0;
    endtask

    task automatic test_reset();
        reset_in  = 1'b1;
        rd_req_in = 1'b1;
        wr_req_in = 1'b1;
        rd_addr_in = 13'h0aa;
        wr_addr_in = 13'h155;
        wr_data_in = 32'h1234_5678;
        step();
        step();
        n_tests++;
        if (rd_grant_out !== 1'b0) begin n_fail++; $display("FAIL reset_rd_grant got %0b exp 0", rd_grant_out); end
        n_tests++;
        if (wr_grant_out !== 1'b0) begin n_fail++; $display("FAIL reset_wr_grant got %0b exp 0", wr_grant_out); end
        n_tests++;
        if (rd_valid_out !== 1'b0 || ram_we_out !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid_we got %0b/%0b exp 0/0", rd_valid_out, ram_we_out);
        end
        n_tests++;
        if (ram_addr_out !== '0 || ram_wdata_out !== '0 || rd_data_out !== '0) begin
            n_fail++;
            $display("FAIL reset_zero addr=%0h wdata=%0h rdata=%0h exp 0", ram_addr_out, ram_wdata_out, rd_data_out);
        end
        reset_in  = 1'b0;
        rd_req_in = 1'b0;
        wr_req_in = 1'b0;
        step();
    endtask

    task automatic test_write_read();
        wr_req_in  = 1'b1;
        wr_addr_in = 13'h0010;
        wr_data_in = 32'hDEAD_BEEF;
        #1;
        n_tests++;
        if (wr_grant_out !== 1'b1 || rd_grant_out !== 1'b0) begin
            n_fail++; $display("FAIL wr_grant got wr=%0b rd=%0b exp 1/0", wr_grant_out, rd_grant_out);
        end
        step();
        wr_req_in  = 1'b0;
        rd_req_in  = 1'b1;
        rd_addr_in = 13'h0010;
        #1;
        n_tests++;
        if (ram_we_out !== 1'b1 || ram_addr_out !== 13'h0010 || ram_wdata_out !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL ram_write got we=%0b addr=%0h data=%0h exp 1/10/deadbeef", ram_we_out, ram_addr_out, ram_wdata_out);
        end
        n_tests++;
        if (rd_grant_out !== 1'b1 || wr_grant_out !== 1'b0) begin
            n_fail++; $display("FAIL rd_grant got rd=%0b wr=%0b exp 1/0", rd_grant_out, wr_grant_out);
        end
        step();
        rd_req_in = 1'b0;
        #1;
        n_tests++;
        if (ram_we_out !== 1'b0 || rd_valid_out !== 1'b0 || ram_addr_out !== 13'h0010) begin
            n_fail++;
            $display("FAIL read_issue got we=%0b valid=%0b addr=%0h exp 0/0/10", ram_we_out, rd_valid_out, ram_addr_out);
        end
        step();
        n_tests++;
        if (rd_valid_out !== 1'b1 || rd_data_out !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL read_return got valid=%0b data=%0h exp 1/deadbeef", rd_valid_out, rd_data_out);
        end
        step();
        n_tests++;
        if (rd_valid_out !== 1'b0) begin n_fail++; $display("FAIL read_single got valid=%0b exp 0", rd_valid_out); end
    endtask

    task automatic test_starvation();
        int bad = 0, overlap = 0, nwr = 0;
        logic exp_rd;
        rd_req_in = 1'b1;
        wr_req_in = 1'b1;
        rd_addr_in = 13'h0100;
        wr_addr_in = 13'h0200;
        wr_data_in = 32'h0;
        for (int i = 0; i < 51; i++) begin
            #1;
            exp_rd = ((i % 17) != 16);
            if (rd_grant_out !== exp_rd || wr_grant_out !== !exp_rd) bad++;
            if (rd_grant_out === 1'b1 && wr_grant_out === 1'b1) overlap++;
            if (wr_grant_out === 1'b1) nwr++;
            step();
        end
        rd_req_in = 1'b0;
        wr_req_in = 1'b0;
        step();
        n_tests++;
        if (bad != 0) begin n_fail++; $display("FAIL starve_pattern got %0d bad cycles exp 0", bad); end
        n_tests++;
        if (overlap != 0 || nwr != 3) begin
            n_fail++; $display("FAIL starve_overlap got overlap=%0d writes=%0d exp 0/3", overlap, nwr);
        end
    endtask

    task automatic test_wr_drop();
        int nrd = 0, nwr_early = 0, after = 0;
        logic seen_wr = 1'b0;
        rd_req_in = 1'b1;
        wr_req_in = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (wr_grant_out === 1'b1) nwr_early++;
            step();
        end
        wr_req_in = 1'b0;
        #1;
        if (wr_grant_out === 1'b1) nwr_early++;
        step();
        wr_req_in = 1'b1;
        for (int i = 0; i < 40 && !seen_wr; i++) begin
            #1;
            if (wr_grant_out === 1'b1) seen_wr = 1'b1;
            else if (rd_grant_out === 1'b1) after++;
            step();
        end
        rd_req_in = 1'b0;
        wr_req_in = 1'b0;
        step();
        nrd = after;
        n_tests++;
        if (nwr_early != 0) begin n_fail++; $display("FAIL drop_early_write got %0d exp 0", nwr_early); end
        n_tests++;
        if (!seen_wr || nrd != 16) begin
            n_fail++; $display("FAIL drop_restart got reads=%0d write_seen=%0b exp 16/1", nrd, seen_wr);
        end
    endtask

    task automatic test_reset_after_grant();
        int bad = 0;
        rd_req_in  = 1'b1;
        rd_addr_in = 13'h0010;
        #1;
        n_tests++;
        if (rd_grant_out !== 1'b1) begin n_fail++; $display("FAIL rst_rd_grant got %0b exp 1", rd_grant_out); end
        step();
        rd_req_in = 1'b0;
        reset_in  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) reset_in = 1'b0;
            #1;
            if (rd_valid_out !== 1'b0) bad++;
            step();
        end
        n_tests++;
        if (bad != 0) begin n_fail++; $display("FAIL rst_discard_read got %0d valid cycles exp 0", bad); end
        bad = 0;
        wr_req_in  = 1'b1;
        wr_addr_in = 13'h0020;
        wr_data_in = 32'hCAFE_F00D;
        #1;
        n_tests++;
        if (wr_grant_out !== 1'b1) begin n_fail++; $display("FAIL rst_wr_grant got %0b exp 1", wr_grant_out); end
        step();
        wr_req_in = 1'b0;
        reset_in  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) reset_in = 1'b0;
            #1;
            if (ram_we_out !== 1'b0) bad++;
            step();
        end
        n_tests++;
        if (bad != 0) begin n_fail++; $display("FAIL rst_discard_write got %0d we cycles exp 0", bad); end
    endtask

    task automatic test_reset_active();
        int bad = 0, nrd = 0;
        logic seen_wr = 1'b0;
        rd_req_in  = 1'b1;
        wr_req_in  = 1'b1;
        rd_addr_in = 13'h0300;
        wr_addr_in = 13'h0400;
        wr_data_in = 32'hA5A5_A5A5;
        for (int i = 0; i < 5; i++) step();
        reset_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (rd_grant_out !== 1'b0 || wr_grant_out !== 1'b0) bad++;
            if (rd_valid_out !== 1'b0 || ram_we_out !== 1'b0 || rd_data_out !== '0) bad++;
            if (i > 0 && (ram_addr_out !== '0 || ram_wdata_out !== '0)) bad++;
            step();
        end
        reset_in = 1'b0;
        for (int i = 0; i < 40 && !seen_wr; i++) begin
            #1;
            if (wr_grant_out === 1'b1) seen_wr = 1'b1;
            else if (rd_grant_out === 1'b1) nrd++;
            step();
        end
        rd_req_in = 1'b0;
        wr_req_in = 1'b0;
        step();
        n_tests++;
        if (bad != 0) begin n_fail++; $display("FAIL rst_active_outputs got %0d nonzero samples exp 0", bad); end
        n_tests++;
        if (!seen_wr || nrd != 16) begin
            n_fail++; $display("FAIL rst_counter_restart got reads=%0d write_seen=%0b exp 16/1", nrd, seen_wr);
        end
    endtask

    task automatic test_write_sweep();
        int gbad = 0, abad = 0, nvalid, nbad;
        // DEPTH+1 writes: the last lands on address 0 again with data 0, so the
        // array still holds data == address afterwards.
        for (int c = 0; c <= DEPTH; c++) begin
            wr_req_in  = 1'b1;
            wr_addr_in = c[AW-1:0];
            wr_data_in = DW'(c % DEPTH);
            #1;
            if (wr_grant_out !== 1'b1) gbad++;
            if (c > 0 && (ram_we_out !== 1'b1 || ram_addr_out !== AW'((c - 1) % DEPTH))) abad++;
            step();
        end
        wr_req_in = 1'b0;
        #1;
        n_tests++;
        if (gbad != 0) begin n_fail++; $display("FAIL sweep_grant got %0d missing grants exp 0", gbad); end
        n_tests++;
        if (abad != 0) begin n_fail++; $display("FAIL sweep_addr got %0d bad cycles exp 0", abad); end
        n_tests++;
        if (ram_addr_out !== '0 || ram_we_out !== 1'b1) begin
            n_fail++; $display("FAIL sweep_wrap got addr=%0h we=%0b exp 0/1", ram_addr_out, ram_we_out);
        end
        step();
        read_burst(DEPTH, nvalid, nbad);
        n_tests++;
        if (nvalid != DEPTH || nbad != 0) begin
            n_fail++; $display("FAIL sweep_readback got valid=%0d bad=%0d exp %0d/0", nvalid, nbad, DEPTH);
        end
    endtask

    task automatic test_back_to_back();
        int nvalid, nbad;
        read_burst(2048, nvalid, nbad);
        n_tests++;
        if (nvalid != 2048 || nbad != 0) begin
            n_fail++; $display("FAIL b2b_reads got valid=%0d bad=%0d exp 2048/0", nvalid, nbad);
        end
    endtask

    initial begin
        reset_in   = 1'b1;
        rd_req_in  = 1'b0;
        wr_req_in  = 1'b0;
        rd_addr_in = '0;
        wr_addr_in = '0;
        wr_data_in = '0;
        test_reset();
        test_write_read();
        test_starvation();
        test_wr_drop();
        test_reset_after_grant();
        test_reset_active();
        test_write_sweep();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired after %0t exp completion", $time);
        $fatal(1);
    end

endmodule

// File: doc/frame_ram_arbiter.md
FRAME_RAM_ARBITER -- requirements
Module: frame_ram_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 13: frame RAM address width.
REQ-002 Parameter DATA_WIDTH, default 32: frame RAM data width.
REQ-003 Parameter STARVE_LIMIT, default 16: maximum number of consecutive read grants while a write is pending.
REQ-004 clk_in  input  1: single system clock; all logic is rising-edge.
REQ-005 reset_in  input  1: synchronous, active-high reset.
REQ-006 rd_req_in  input  1: display read controller requests one word.
REQ-007 rd_addr_in  input  ADDR_WIDTH: read word address.
REQ-008 rd_grant_out  output  1: read request accepted this cycle.
REQ-009 rd_data_out  output  DATA_WIDTH: read data.
REQ-010 rd_valid_out  output  1: rd_data_out is valid this cycle.
REQ-011 wr_req_in  input  1: host writer requests one word write.
REQ-012 wr_addr_in  input  ADDR_WIDTH: write word address.
REQ-013 wr_data_in  input  DATA_WIDTH: write data.
REQ-014 wr_grant_out  output  1: write request accepted this cycle.
REQ-015 ram_we_out  output  1: frame RAM write enable.
REQ-016 ram_addr_out  output  ADDR_WIDTH: frame RAM address.
REQ-017 ram_wdata_out  output  DATA_WIDTH: frame RAM write data.
REQ-018 ram_rdata_in  input  DATA_WIDTH: frame RAM read data; 1-cycle registered read latency.

Function
REQ-019 Grants are combinational in the request cycle; a transfer occurs when req and grant are both high on a rising edge.
REQ-020 At most one of rd_grant_out and wr_grant_out shall be high in any cycle.
REQ-021 Requesters hold req, addr and data stable until granted.
REQ-022 Arbitration is fixed-priority to reads, except in the starvation case defined in REQ-023.
REQ-023 Starvation counter: increments on each read grant while wr_req_in is high; clears on any write grant or when wr_req_in is low; when it equals STARVE_LIMIT and both requests are high, the write is granted.
REQ-024 Starvation counter width is clog2(STARVE_LIMIT+1) and never exceeds STARVE_LIMIT.
REQ-025 RAM outputs are registered. After grant cycle N, ram_addr_out, ram_we_out and ram_wdata_out carry that access during cycle N+1.
REQ-026 In any cycle with no grant, ram_we_out is 0 in the following cycle; ram_addr_out and ram_wdata_out hold their previous values.
REQ-027 Read latency: a read granted in cycle N gives rd_valid_out=1 in cycle N+2, with rd_data_out=ram_rdata_in in that cycle.
REQ-028 rd_valid_out is a 2-stage valid pipeline; back-to-back read grants give back-to-back valid cycles, in order.
REQ-029 Write then read of the same address: a write granted in cycle N followed by a read granted in cycle N+1 returns the new data (RAM write-first, sequential access).
REQ-030 No combinational path from ram_rdata_in to any grant.

Reset
REQ-031 While reset_in is high at a rising edge, the block clears rd_grant_out, wr_grant_out, rd_valid_out, ram_we_out, the valid pipeline and the starvation counter.
REQ-032 While reset_in is high at a rising edge, ram_addr_out, ram_wdata_out and rd_data_out are 0.
REQ-033 Reset mid-operation discards in-flight reads: no rd_valid_out pulse occurs after reset asserts.
REQ-034 Reset mid-operation discards pending writes: no ram_we_out pulse occurs after reset asserts.
REQ-035 Grants are suppressed while reset_in is high.
REQ-036 Operation resumes the first cycle after reset_in goes low.

Verification
REQ-037 Scenario: write 0xDEADBEEF to address 0x0010, then read address 0x0010 -> wr_grant_out high for 1 cycle, ram_we_out high 1 cycle later, rd_valid_out high 2 cycles after the read grant with rd_data_out=0xDEADBEEF.
REQ-038 Scenario: rd_req_in and wr_req_in held high continuously -> exactly 16 read grants, then 1 write grant, repeating; grants never overlap.
REQ-039 Scenario: 2048 back-to-back reads of addresses 0..2047 over a preloaded ramp pattern -> 2048 consecutive rd_valid_out cycles with data equal to address, in order.
REQ-040 Scenario: write only, all 8192 addresses -> one write grant per cycle and ram_addr_out sweeps 0..8191 wrapping to 0; readback matches.
REQ-041 Scenario: reset_in asserted one cycle after a read grant -> no rd_valid_out.
REQ-042 Scenario: reset_in asserted while reads are active -> all outputs 0 during reset; the starvation counter restarts from 0 after release.
REQ-043 Scenario: wr_req_in dropped after 10 contended read grants, then reasserted -> the counter restarts and the next forced write occurs after 16 further read grants.
